musa_boot_loader: RTL

- Upstream stage of the MUSA core: receives a program image as a byte stream and writes it, word by word, into instruction memory through its write port.
- Holds the core in reset (core_rst_n low) while loading.
- Releases the core only after a complete image with a valid checksum has been written, so the PC starts fetching at address 0 from a known image.
- Reports load errors and supports reload on a new start pulse.

---
 rtl/musa_boot_pkg.sv | 26 ++
 rtl/musa_boot_assembler.sv | 67 ++++++
 rtl/musa_boot_loader.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/musa_boot_pkg.sv
// Shared definitions for the MUSA boot loader: FSM states, error codes and
// the width of the image length field.
package musa_boot_pkg;

    // Width of the big-endian word-count field at the head of an image.
    localparam int LEN_W = 16;

    // Loader FSM states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_CHECK  = 3'd5,
        ST_RUN    = 3'd6,
        ST_FAIL   = 3'd7
    } state_t;

    // Values reported on err_code.
    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_CKSUM   = 2'b01;
    localparam logic [1:0] ERR_SIZE    = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

endpackage : musa_boot_pkg

// File: rtl/musa_boot_assembler.sv
// Byte-to-word assembler for the boot loader. Shifts data bytes MSB-first
// into a 32-bit word, tracks the byte position within the word and keeps a
// running XOR over every accepted byte (length bytes included).
module musa_boot_assembler
    import musa_boot_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,      // restart: drop partial word and checksum
    input  logic        byte_en,    // any accepted byte (feeds the checksum)
    input  logic        word_en,    // accepted byte that belongs to a data word
    input  logic [7:0]  rx_data,
    output logic        word_ready, // this accept completes a word
    output logic [31:0] word,
    output logic [7:0]  checksum
);

    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [31:0] word_q, word_d;
    logic [7:0]  cksum_q, cksum_d;
    logic [31:0] word_shifted;

    // Lane-wise shift: each byte lane takes the lane below it, lane 0 takes
    // the new byte, so the first byte of a word ends up in the top lane.
    assign word_shifted[7:0] = rx_data;
    for (genvar gi = 1; gi < 4; gi++) begin : g_lane
        assign word_shifted[gi*8 +: 8] = word_q[(gi-1)*8 +: 8];
    end

    assign word_ready = word_en && (byte_idx_q == 2'd3);
    assign word       = word_q;
    assign checksum   = cksum_q;

    // Next-state for the shift register, byte index and checksum; clear wins.
    always_comb begin
        byte_idx_d = byte_idx_q;
        word_d     = word_q;
        cksum_d    = cksum_q;
        if (clear) begin
            byte_idx_d = 2'd0;
            word_d     = '0;
            cksum_d    = '0;
        end else begin
            if (byte_en) begin
                cksum_d = cksum_q ^ rx_data;
            end
            if (word_en) begin
                word_d     = word_shifted;
                byte_idx_d = byte_idx_q + 2'd1;
            end
        end
    end

    // Assembler registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_idx_q <= 2'd0;
            word_q     <= '0;
            cksum_q    <= '0;
        end else begin
            byte_idx_q <= byte_idx_d;
            word_q     <= word_d;
            cksum_q    <= cksum_d;
        end
    end

endmodule : musa_boot_assembler

// File: rtl/musa_boot_loader.sv
// MUSA boot loader: receives a length-prefixed, XOR-checksummed program image
// as a byte stream, writes it word by word into instruction memory and holds
// the core in reset until a complete image with a valid checksum is loaded.
module musa_boot_loader
    import musa_boot_pkg::*;
#(
    parameter int ADDR_W      = 18,
    parameter int MAX_WORDS   = 1024,
    parameter int BASE_ADDR   = 0,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              imem_wren,
    output logic              core_rst_n,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code
);

    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [LEN_W-1:0]  MAX_LEN   = LEN_W'(MAX_WORDS);
    localparam logic [ADDR_W-1:0] BASE_ADDR_L = ADDR_W'(BASE_ADDR);

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  word_idx_q, word_idx_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [1:0]        err_q, err_d;

    logic              accept;
    logic              word_en;
    logic              word_ready;
    logic [7:0]        checksum;
    logic [LEN_W-1:0]  len_shifted;
    logic [LEN_W-1:0]  word_idx_inc;

    // Byte-stream side: the loader only listens while it expects a byte, and
    // the timeout counter runs in exactly those states as well.
    assign rx_ready = (state_q == ST_LEN_HI) || (state_q == ST_LEN_LO) ||
                      (state_q == ST_DATA)   || (state_q == ST_CHECK);
    assign accept   = rx_valid && rx_ready;
    assign word_en  = accept && (state_q == ST_DATA);

    assign len_shifted  = {len_q[LEN_W-9:0], rx_data};
    assign word_idx_inc = word_idx_q + 16'd1;

    // Status and memory outputs are decoded straight from registered state,
    // so an asynchronous reset forces them to their idle values at once.
    assign imem_wren  = (state_q == ST_WRITE);
    assign imem_addr  = BASE_ADDR_L + ADDR_W'(word_idx_q);
    assign core_rst_n = (state_q == ST_RUN);
    assign done       = (state_q == ST_RUN);
    assign error      = (state_q == ST_FAIL);
    assign busy       = rx_ready || (state_q == ST_WRITE);
    assign err_code   = err_q;

    musa_boot_assembler u_asm (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (start),
        .byte_en    (accept),
        .word_en    (word_en),
        .rx_data    (rx_data),
        .word_ready (word_ready),
        .word       (imem_wdata),
        .checksum   (checksum)
    );

    // Next-state logic: start overrides everything, then the per-state
    // handshake, then the inter-byte timeout.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_idx_d = word_idx_q;
        to_cnt_d   = to_cnt_q;
        err_d      = err_q;

        if (start) begin
            state_d    = ST_LEN_HI;
            len_d      = '0;
            word_idx_d = '0;
            to_cnt_d   = '0;
            err_d      = ERR_NONE;
        end else begin
            case (state_q)
                ST_LEN_HI: begin
                    if (accept) begin
                        len_d   = len_shifted;
                        state_d = ST_LEN_LO;
                    end
                end
                ST_LEN_LO: begin
                    if (accept) begin
                        len_d = len_shifted;
                        if (len_shifted > MAX_LEN) begin
                            state_d = ST_FAIL;
                            err_d   = ERR_SIZE;
                        end else if (len_shifted == '0) begin
                            state_d = ST_CHECK;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (word_ready) begin
                        state_d = ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    word_idx_d = word_idx_inc;
                    state_d    = (word_idx_inc == len_q) ? ST_CHECK : ST_DATA;
                end
                ST_CHECK: begin
                    if (accept) begin
                        if (rx_data == checksum) begin
                            state_d = ST_RUN;
                        end else begin
                            state_d = ST_FAIL;
                            err_d   = ERR_CKSUM;
                        end
                    end
                end
                default: begin
                    // IDLE, RUN and FAIL wait for start.
                end
            endcase

            // Inter-byte watchdog: any accept re-arms it; WRITE holds it.
            if (rx_ready) begin
                if (accept) begin
                    to_cnt_d = '0;
                end else if (to_cnt_q == TO_LAST) begin
                    state_d = ST_FAIL;
                    err_d   = ERR_TIMEOUT;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
        end
    end

    // Loader state, length, word index, timeout and error registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            word_idx_q <= '0;
            to_cnt_q   <= '0;
            err_q      <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_idx_q <= word_idx_d;
            to_cnt_q   <= to_cnt_d;
            err_q      <= err_d;
        end
    end

endmodule : musa_boot_loader
